// File: rtl/sync_fifo_pf_pkg.sv
// Shared definitions for the single-clock FIFO and its dual-clock companion.
// Read-mode constants and depth derivation live here so both wrappers agree.
`ifndef SYNC_FIFO_DEPTH
`define SYNC_FIFO_DEPTH(addr) (1 << (addr))
`endif

package sync_fifo_pf_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    function automatic int unsigned fifo_depth(input int unsigned addr);
        return 32'd1 << addr;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read.
// No reset on the array; contents are only meaningful between the pointers.
module sync_fifo_mem
    import sync_fifo_pf_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = fifo_depth(ADDR);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_pf.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_pf
    import sync_fifo_pf_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 3,
    parameter int unsigned FWFT  = FWFT_OFF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             RD_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic [ADDR:0]    COUNT,
    input  logic [ADDR:0]    AF_THRESH,
    input  logic [ADDR:0]    AE_THRESH,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    input  logic             ERR_CLR
);

    localparam int unsigned   DEPTH    = fifo_depth(ADDR);
    localparam logic [ADDR:0] FULL_CNT = (ADDR + 1)'(DEPTH);

    logic [ADDR:0]    wptr_q, wptr_d;
    logic [ADDR:0]    rptr_q, rptr_d;
    logic [ADDR:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full, empty;
    logic             wa, ra, load;
    logic [WIDTH-1:0] mem_rdata;

    sync_fifo_mem #(
        .WIDTH(WIDTH),
        .ADDR (ADDR)
    ) u_mem (
        .clk_i  (CLK),
        .we_i   (wa),
        .waddr_i(wptr_q[ADDR-1:0]),
        .wdata_i(WR_DATA),
        .raddr_i(rptr_q[ADDR-1:0]),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
        wa    = WR_EN & ~full;
        ra    = 1'b0;
        load  = 1'b0;

        if (FWFT == FWFT_ON) begin
            // Output register refills from memory on the same edge it is popped.
            ra   = RD_EN & out_valid_q;
            load = (wptr_q != rptr_q) & (~out_valid_q | ra);
            out_valid_d = load | (out_valid_q & ~ra);
        end else begin
            ra   = RD_EN & ~empty;
            load = ra;
            out_valid_d = ra;
        end
        out_data_d = load ? mem_rdata : out_data_q;

        wptr_d = wptr_q + {{ADDR{1'b0}}, wa};
        rptr_d = rptr_q + {{ADDR{1'b0}}, load};

        case ({wa, ra})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set takes priority over a simultaneous clear.
        ovf_d = (ovf_q & ~ERR_CLR) | (WR_EN & full);
        unf_d = (unf_q & ~ERR_CLR) | (RD_EN & ~ra);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign RD_DATA      = out_data_q;
    assign RD_VALID     = out_valid_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign COUNT        = count_q;
    assign ALMOST_FULL  = (count_q >= AF_THRESH);
    assign ALMOST_EMPTY = (count_q <= AE_THRESH);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_sync_fifo_pf.sv
// Bench for sync_fifo_pf: one standard-mode and one FWFT instance share inputs
// and are checked against queue-based reference models.
module tb_sync_fifo_pf;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, err_clr;
    logic [7:0] wr_data;
    logic [3:0] af_th, ae_th;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] s_count, f_count;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic [7:0] s_exp_data;
    bit         s_exp_valid, s_ovf_m, s_unf_m, f_ovf_m, f_unf_m, f_vis;

    always #5 clk = ~clk;

    sync_fifo_pf #(.WIDTH(8), .ADDR(3), .FWFT(0)) dut_std (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
        .RD_DATA(s_rd_data), .RD_VALID(s_rd_valid), .FULL(s_full), .EMPTY(s_empty),
        .COUNT(s_count), .AF_THRESH(af_th), .AE_THRESH(ae_th), .ALMOST_FULL(s_af),
        .ALMOST_EMPTY(s_ae), .OVERFLOW(s_ovf), .UNDERFLOW(s_unf), .ERR_CLR(err_clr)
    );

    sync_fifo_pf #(.WIDTH(8), .ADDR(3), .FWFT(1)) dut_fwft (
        .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
        .RD_DATA(f_rd_data), .RD_VALID(f_rd_valid), .FULL(f_full), .EMPTY(f_empty),
        .COUNT(f_count), .AF_THRESH(af_th), .AE_THRESH(ae_th), .ALMOST_FULL(f_af),
        .ALMOST_EMPTY(f_ae), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf), .ERR_CLR(err_clr)
    );

    // Drive one cycle of inputs, advance the models at the edge, settle 1 time unit.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c,
                        input bit rs);
        bit sra, swa, fra, fwa;
        int stored;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            sq.delete(); fq.delete();
            s_exp_data = 8'h00; s_exp_valid = 0;
            s_ovf_m = 0; s_unf_m = 0; f_ovf_m = 0; f_unf_m = 0; f_vis = 0;
        end else begin
            sra = r && sq.size() > 0;
            swa = w && sq.size() < 8;
            s_ovf_m = (s_ovf_m && !c) || (w && sq.size() == 8);
            s_unf_m = (s_unf_m && !c) || (r && !sra);
            if (sra) s_exp_data = sq.pop_front();
            s_exp_valid = sra;
            if (swa) sq.push_back(d);

            fra = r && f_vis;
            fwa = w && fq.size() < 8;
            stored = int'(fq.size()) - int'(f_vis);
            f_ovf_m = (f_ovf_m && !c) || (w && fq.size() == 8);
            f_unf_m = (f_unf_m && !c) || (r && !fra);
            if (fra) void'(fq.pop_front());
            f_vis = (f_vis && !fra) || (stored > 0);
            if (fwa) fq.push_back(d);
        end
        #1;
        wr_en = 0; rd_en = 0; err_clr = 0; rst = 0;
    endtask

    task automatic test_reset();
        af_th = 4'd6; ae_th = 4'd2;
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        ntests++; if (s_count !== 4'd0) begin nfail++; $display("FAIL reset_count: got %0d want 0", s_count); end
        ntests++; if (s_empty !== 1'b1) begin nfail++; $display("FAIL reset_empty: got %b want 1", s_empty); end
        ntests++; if (s_full !== 1'b0) begin nfail++; $display("FAIL reset_full: got %b want 0", s_full); end
        ntests++; if (s_rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", s_rd_valid); end
        ntests++; if (s_ae !== 1'b1) begin nfail++; $display("FAIL reset_ae: got %b want 1", s_ae); end
        ntests++; if (s_af !== 1'b0) begin nfail++; $display("FAIL reset_af: got %b want 0", s_af); end
        ntests++; if (s_rd_data !== 8'h00) begin nfail++; $display("FAIL reset_data: got %h want 00", s_rd_data); end
        ntests++; if (f_rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_fvalid: got %b want 0", f_rd_valid); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 9; i++) begin
            step(1, 8'(i), 0, 0, 0);
            ntests++; if (s_count !== 4'((i > 8) ? 8 : i)) begin nfail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, (i > 8) ? 8 : i); end
            ntests++; if (s_full !== (i >= 8)) begin nfail++; $display("FAIL fill_full[%0d]: got %b want %b", i, s_full, i >= 8); end
            ntests++; if (s_af !== (i >= 6)) begin nfail++; $display("FAIL fill_af[%0d]: got %b want %b", i, s_af, i >= 6); end
            ntests++; if (s_ovf !== (i == 9)) begin nfail++; $display("FAIL fill_ovf[%0d]: got %b want %b", i, s_ovf, i == 9); end
        end
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        ntests++; if (s_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_sticky: got %b want 1", s_ovf); end
        step(0, 8'h00, 0, 1, 0);
        ntests++; if (s_ovf !== 1'b0) begin nfail++; $display("FAIL ovf_clear: got %b want 0", s_ovf); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(0, 8'h00, 1, 0, 0);
            ntests++; if (s_rd_valid !== 1'b1) begin nfail++; $display("FAIL drain_valid[%0d]: got %b want 1", i, s_rd_valid); end
            ntests++; if (s_rd_data !== 8'(i)) begin nfail++; $display("FAIL drain_data[%0d]: got %h want %h", i, s_rd_data, 8'(i)); end
        end
        step(0, 8'h00, 1, 0, 0);
        ntests++; if (s_unf !== 1'b1) begin nfail++; $display("FAIL drain_unf: got %b want 1", s_unf); end
        ntests++; if (s_rd_valid !== 1'b0) begin nfail++; $display("FAIL drain_novalid: got %b want 0", s_rd_valid); end
        ntests++; if (s_rd_data !== 8'h08) begin nfail++; $display("FAIL drain_hold: got %h want 08", s_rd_data); end
        ntests++; if (s_empty !== 1'b1) begin nfail++; $display("FAIL drain_empty: got %b want 1", s_empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] want;
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'h50 + 8'(i), 1, 0, 0);
            want = (i < 4) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 4);
            ntests++; if (s_count !== 4'd4) begin nfail++; $display("FAIL wrap_count[%0d]: got %0d want 4", i, s_count); end
            ntests++; if (s_rd_valid !== 1'b1 || s_rd_data !== want) begin nfail++; $display("FAIL wrap_data[%0d]: got %b/%h want 1/%h", i, s_rd_valid, s_rd_data, want); end
        end
    endtask

    task automatic test_fwft_latency();
        logic [7:0] want [3];
        want[0] = 8'h11; want[1] = 8'h22;
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hA5, 0, 0, 0);
        ntests++; if (f_count !== 4'd1) begin nfail++; $display("FAIL fwft_count1: got %0d want 1", f_count); end
        ntests++; if (f_rd_valid !== 1'b0) begin nfail++; $display("FAIL fwft_early: got %b want 0", f_rd_valid); end
        step(0, 8'h00, 0, 0, 0);
        ntests++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5) begin nfail++; $display("FAIL fwft_first: got %b/%h want 1/a5", f_rd_valid, f_rd_data); end
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        ntests++; if (f_count !== 4'd3 || f_rd_data !== 8'hA5) begin nfail++; $display("FAIL fwft_pre: got %0d/%h want 3/a5", f_count, f_rd_data); end
        for (int i = 0; i < 2; i++) begin
            step(0, 8'h00, 1, 0, 0);
            ntests++; if (f_rd_valid !== 1'b1 || f_rd_data !== want[i]) begin nfail++; $display("FAIL fwft_pop[%0d]: got %b/%h want 1/%h", i, f_rd_valid, f_rd_data, want[i]); end
        end
        step(0, 8'h00, 1, 0, 0);
        ntests++; if (f_rd_valid !== 1'b0 || f_count !== 4'd0) begin nfail++; $display("FAIL fwft_end: got %b/%0d want 0/0", f_rd_valid, f_count); end
        ntests++; if (f_unf !== 1'b0) begin nfail++; $display("FAIL fwft_nounf: got %b want 0", f_unf); end
    endtask

    task automatic test_mid_reset();
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 8'hE0 + 8'(i), 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        ntests++; if (s_count !== 4'd5 || s_ovf !== 1'b1) begin nfail++; $display("FAIL mid_pre: got %0d/%b want 5/1", s_count, s_ovf); end
        step(1, 8'h77, 1, 0, 1);
        ntests++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin nfail++; $display("FAIL mid_count: got %0d/%b/%b want 0/1/0", s_count, s_empty, s_full); end
        ntests++; if (s_ovf !== 1'b0 || s_unf !== 1'b0) begin nfail++; $display("FAIL mid_flags: got %b/%b want 0/0", s_ovf, s_unf); end
        ntests++; if (s_rd_valid !== 1'b0 || s_rd_data !== 8'h00) begin nfail++; $display("FAIL mid_out: got %b/%h want 0/00", s_rd_valid, s_rd_data); end
        ntests++; if (f_count !== 4'd0 || f_rd_valid !== 1'b0 || f_ovf !== 1'b0) begin nfail++; $display("FAIL mid_fwft: got %0d/%b/%b want 0/0/0", f_count, f_rd_valid, f_ovf); end
        step(1, 8'h3C, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        ntests++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'h3C) begin nfail++; $display("FAIL mid_std_new: got %b/%h want 1/3c", s_rd_valid, s_rd_data); end
        ntests++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'h3C) begin nfail++; $display("FAIL mid_fwft_new: got %b/%h want 1/3c", f_rd_valid, f_rd_data); end
    endtask

    task automatic test_random();
        bit w, r, c, rs, eb;
        int wprob;
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                af_th = 4'($urandom_range(0, 15));
                ae_th = 4'($urandom_range(0, 15));
            end
            wprob = ((i / 40) % 2 == 0) ? 70 : 30;
            w  = $urandom_range(0, 99) < wprob;
            r  = $urandom_range(0, 99) < (100 - wprob);
            c  = $urandom_range(0, 7) == 0;
            rs = $urandom_range(0, 99) == 0;
            step(w, 8'($urandom), r, c, rs);

            ntests++; if (s_count !== 4'(sq.size())) begin nfail++; $display("FAIL rnd_scount[%0d]: got %0d want %0d", i, s_count, sq.size()); end
            ntests++; if (s_rd_valid !== s_exp_valid || s_rd_data !== s_exp_data) begin nfail++; $display("FAIL rnd_sdata[%0d]: got %b/%h want %b/%h", i, s_rd_valid, s_rd_data, s_exp_valid, s_exp_data); end
            ntests++; if (s_ovf !== s_ovf_m || s_unf !== s_unf_m) begin nfail++; $display("FAIL rnd_sflags[%0d]: got %b/%b want %b/%b", i, s_ovf, s_unf, s_ovf_m, s_unf_m); end
            eb = int'(sq.size()) >= int'(af_th);
            ntests++; if (s_af !== eb) begin nfail++; $display("FAIL rnd_saf[%0d]: got %b want %b", i, s_af, eb); end
            eb = int'(sq.size()) <= int'(ae_th);
            ntests++; if (s_ae !== eb) begin nfail++; $display("FAIL rnd_sae[%0d]: got %b want %b", i, s_ae, eb); end
            ntests++; if (s_full !== (sq.size() == 8) || s_empty !== (sq.size() == 0)) begin nfail++; $display("FAIL rnd_sfe[%0d]: got %b/%b size %0d", i, s_full, s_empty, sq.size()); end

            ntests++; if (f_count !== 4'(fq.size())) begin nfail++; $display("FAIL rnd_fcount[%0d]: got %0d want %0d", i, f_count, fq.size()); end
            ntests++; if (f_rd_valid !== f_vis) begin nfail++; $display("FAIL rnd_fvalid[%0d]: got %b want %b", i, f_rd_valid, f_vis); end
            if (f_vis) begin
                ntests++; if (f_rd_data !== fq[0]) begin nfail++; $display("FAIL rnd_fdata[%0d]: got %h want %h", i, f_rd_data, fq[0]); end
            end
            ntests++; if (f_ovf !== f_ovf_m || f_unf !== f_unf_m) begin nfail++; $display("FAIL rnd_fflags[%0d]: got %b/%b want %b/%b", i, f_ovf, f_unf, f_ovf_m, f_unf_m); end
            ntests++; if (f_full !== (fq.size() == 8)) begin nfail++; $display("FAIL rnd_ffull[%0d]: got %b size %0d", i, f_full, fq.size()); end
        end
    endtask

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = 8'h00;
        af_th = 4'd6; ae_th = 4'd2;
        test_reset();
        test_fill_overflow();
        test_drain();
        test_wrap();
        test_fwft_latency();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
